card_shoe: RTL and testbench

Parametrised multi-deck card shoe for the blackjack datapath. It holds NUM_DECKS standard 52-card decks and deals pseudo-random cards without repetition until the shoe is empty. Each dealt card comes with its rank, suit, blackjack point value and ace flag, which feed the player/dealer score adders and the display path. It also exposes a draw handshake, a cards-remaining count and a reshuffle command.

---
 rtl/card_shoe.sv | 80 ++++++++
 tb/tb_card_shoe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/card_shoe.sv
// card_shoe: multi-deck card shoe dealing pseudo-random cards without repetition.
module card_shoe #(
  parameter int          NUM_DECKS = 1,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int         CLW       = $clog2(52*NUM_DECKS+1),
  localparam int         EW        = $clog2(NUM_DECKS+1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           shuffle,
  input  logic           draw_req,
  output logic           draw_ready,
  output logic           card_valid,
  output logic [3:0]     card_rank,
  output logic [1:0]     card_suit,
  output logic [3:0]     card_points,
  output logic           card_is_ace,
  output logic [CLW-1:0] cards_left,
  output logic           empty,
  output logic           busy
);
  typedef enum logic [1:0] {FILL, IDLE, PROBE} state_t;
  state_t state;
  logic [5:0] idx, ptr, cand;
  logic [15:0] lfsr, lfsr_nxt;
  logic [EW-1:0] cnt [52];
  logic hit;
  logic [3:0] rank;
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign cand = lfsr[5:0] >= 6'd52 ? lfsr[5:0] - 6'd52 : lfsr[5:0];
  assign hit = cnt[ptr] != '0;
  assign rank = ptr[5:2] + 4'd1;
  assign draw_ready = state == IDLE && cards_left != '0;
  assign empty = state == IDLE && cards_left == '0;
  assign busy = state != IDLE;
  // Count storage has no reset: FILL rewrites every entry before IDLE can read it.
  always_ff @(posedge clk)
    if (!reset && !shuffle && state == FILL) cnt[idx] <= EW'(NUM_DECKS);
    else if (!reset && !shuffle && state == PROBE && hit) cnt[ptr] <= cnt[ptr] - EW'(1);
  always_ff @(posedge clk)
    if (reset) begin
      state <= FILL;
      idx <= '0;
      ptr <= '0;
      lfsr <= SEED;
      cards_left <= '0;
      card_valid <= 1'b0;
      card_rank <= '0;
      card_suit <= '0;
      card_points <= '0;
      card_is_ace <= 1'b0;
    end else begin
      lfsr <= lfsr_nxt;
      card_valid <= 1'b0;
      if (shuffle) begin
        state <= FILL;
        idx <= '0;
        cards_left <= '0;
      end else if (state == FILL) begin
        idx <= idx + 6'd1;
        if (idx == 6'd51) begin
          state <= IDLE;
          cards_left <= CLW'(52*NUM_DECKS);
        end
      end else if (state == IDLE) begin
        if (draw_req && draw_ready) begin
          ptr <= cand;
          state <= PROBE;
        end
      end else if (hit) begin
        cards_left <= cards_left - CLW'(1);
        card_valid <= 1'b1;
        card_rank <= rank;
        card_suit <= ptr[1:0];
        card_points <= rank >= 4'd10 ? 4'd10 : rank;
        card_is_ace <= rank == 4'd1;
        state <= IDLE;
      end else ptr <= ptr == 6'd51 ? 6'd0 : ptr + 6'd1;
    end
endmodule

// File: tb/tb_card_shoe.sv
// tb_card_shoe: scoreboard bench for card_shoe with one- and two-deck instances.
module tb_card_shoe;
  localparam logic [15:0] SEED = 16'hACE1;
  typedef struct {int idx; int left; int acc; int due;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic shuffle = 1'b0;
  logic draw_req [2];
  logic d1_ready, d1_valid, d1_ace, d1_empty, d1_busy;
  logic [3:0] d1_rank, d1_pts;
  logic [1:0] d1_suit;
  logic [5:0] d1_left;
  logic d2_ready, d2_valid, d2_ace, d2_empty, d2_busy;
  logic [3:0] d2_rank, d2_pts;
  logic [1:0] d2_suit;
  logic [6:0] d2_left;
  logic o_ready [2], o_valid [2], o_ace [2], o_empty [2], o_busy [2];
  logic [3:0] o_rank [2], o_pts [2];
  logic [1:0] o_suit [2];
  logic [6:0] o_left [2];
  int n_tests = 0, n_fail = 0, cyc_n = 0;
  int m_cnt [2][52];
  logic [15:0] m_lfsr [2];
  int m_st [2], m_fidx [2], m_left [2], m_wait [2];
  bit m_vexp [2];
  exp_t q0[$], q1[$];
  int seq_a [52], seq_b [52];

  always #5 clk = ~clk;

  card_shoe #(.NUM_DECKS(1), .SEED(SEED)) d1 (
    .clk(clk), .reset(reset), .shuffle(shuffle), .draw_req(draw_req[0]),
    .draw_ready(d1_ready), .card_valid(d1_valid), .card_rank(d1_rank), .card_suit(d1_suit),
    .card_points(d1_pts), .card_is_ace(d1_ace), .cards_left(d1_left), .empty(d1_empty), .busy(d1_busy));
  card_shoe #(.NUM_DECKS(2), .SEED(SEED)) d2 (
    .clk(clk), .reset(reset), .shuffle(shuffle), .draw_req(draw_req[1]),
    .draw_ready(d2_ready), .card_valid(d2_valid), .card_rank(d2_rank), .card_suit(d2_suit),
    .card_points(d2_pts), .card_is_ace(d2_ace), .cards_left(d2_left), .empty(d2_empty), .busy(d2_busy));

  assign o_ready[0] = d1_ready;
  assign o_ready[1] = d2_ready;
  assign o_valid[0] = d1_valid;
  assign o_valid[1] = d2_valid;
  assign o_ace[0] = d1_ace;
  assign o_ace[1] = d2_ace;
  assign o_empty[0] = d1_empty;
  assign o_empty[1] = d2_empty;
  assign o_busy[0] = d1_busy;
  assign o_busy[1] = d2_busy;
  assign o_rank[0] = d1_rank;
  assign o_rank[1] = d2_rank;
  assign o_pts[0] = d1_pts;
  assign o_pts[1] = d2_pts;
  assign o_suit[0] = d1_suit;
  assign o_suit[1] = d2_suit;
  assign o_left[0] = {1'b0, d1_left};
  assign o_left[1] = d2_left;

  // Transaction model: on accept it scans ahead for the card and pushes the predicted deal.
  task automatic step();
    for (int k = 0; k < 2; k++) begin
      int nd, c, p;
      exp_t e;
      nd = k + 1;
      m_vexp[k] = 1'b0;
      if (reset || shuffle) begin
        if (reset) m_lfsr[k] = SEED;
        m_st[k] = 0;
        m_fidx[k] = 0;
        m_left[k] = 0;
        if (k == 0) q0.delete(); else q1.delete();
      end else if (m_st[k] == 0) begin
        m_cnt[k][m_fidx[k]] = nd;
        if (m_fidx[k] == 51) begin
          m_st[k] = 1;
          m_left[k] = 52 * nd;
        end
        m_fidx[k]++;
      end else if (m_st[k] == 1) begin
        if (draw_req[k] && m_left[k] != 0) begin
          c = int'(m_lfsr[k][5:0]);
          if (c >= 52) c -= 52;
          p = 0;
          while (p < 52 && m_cnt[k][(c + p) % 52] == 0) p++;
          m_cnt[k][(c + p) % 52]--;
          e = '{(c + p) % 52, m_left[k] - 1, cyc_n, cyc_n + 2 + p};
          if (k == 0) q0.push_back(e); else q1.push_back(e);
          m_st[k] = 2;
          m_wait[k] = p + 1;
        end
      end else begin
        m_wait[k]--;
        if (m_wait[k] == 0) begin
          m_st[k] = 1;
          m_left[k]--;
          m_vexp[k] = 1'b1;
        end
      end
      if (!reset) m_lfsr[k] = {1'b0, m_lfsr[k][15:1]} ^ (m_lfsr[k][0] ? 16'hB400 : 16'h0000);
    end
    cyc_n++;
  endtask

  task automatic cyc();
    step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
    n_tests++;
    if ({d1_valid, d1_rank, d1_suit, d1_pts, d1_ace, d1_left, d1_ready, d1_empty, d1_busy} !== 20'b1)
      begin n_fail++; $display("FAIL reset_values: got v=%b r=%0d s=%0d p=%0d a=%b left=%0d rdy=%b emp=%b busy=%b, want all 0 except busy=1",
        d1_valid, d1_rank, d1_suit, d1_pts, d1_ace, d1_left, d1_ready, d1_empty, d1_busy); end
    for (int i = 0; i < 52; i++) begin
      n_tests++;
      if (d1_ready !== 1'b0 || d1_busy !== 1'b1)
        begin n_fail++; $display("FAIL fill_cycle%0d: got ready=%b busy=%b, want 0 1", i, d1_ready, d1_busy); end
      cyc();
    end
    n_tests++;
    if ({d1_ready, d1_left, d1_empty, d1_busy} !== {1'b1, 6'd52, 1'b0, 1'b0})
      begin n_fail++; $display("FAIL fill_done: got ready=%b left=%0d empty=%b busy=%b, want 1 52 0 0", d1_ready, d1_left, d1_empty, d1_busy); end
    n_tests++;
    if (d2_left !== 7'd104) begin n_fail++; $display("FAIL fill_done_2deck: got left=%0d, want 104", d2_left); end
  endtask

  task automatic test_drain(input int k, input int run);
    int nd, got, pulses, guard, bad, lat;
    int seen [52];
    exp_t e;
    logic [3:0] er, ep;
    nd = k + 1;
    got = 0;
    pulses = 0;
    guard = 0;
    foreach (seen[i]) seen[i] = 0;
    draw_req[k] = 1'b1;
    while (got < 52 * nd && guard < 60 * 52 * nd) begin
      cyc();
      guard++;
      n_tests++;
      if ({o_ready[k], o_busy[k], o_empty[k], o_left[k]} !==
          {m_st[k] == 1 && m_left[k] != 0, m_st[k] != 1, m_st[k] == 1 && m_left[k] == 0, 7'(m_left[k])})
        begin n_fail++; $display("FAIL drain%0d_status cyc %0d: got ready=%b busy=%b empty=%b left=%0d, want model state %0d left %0d",
          nd, cyc_n, o_ready[k], o_busy[k], o_empty[k], o_left[k], m_st[k], m_left[k]); end
      if (o_valid[k]) begin
        pulses++;
        n_tests++;
        if ((k == 0 ? q0.size() : q1.size()) == 0) begin
          n_fail++;
          $display("FAIL drain%0d_unexpected_card: got rank=%0d suit=%0d, want no card", nd, o_rank[k], o_suit[k]);
        end else begin
          if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
          er = 4'(e.idx / 4 + 1);
          ep = er == 4'd1 ? 4'd1 : er >= 4'd10 ? 4'd10 : er;
          if ({o_rank[k], o_suit[k], o_pts[k], o_ace[k], o_left[k]} !== {er, 2'(e.idx % 4), ep, er == 4'd1, 7'(e.left)})
            begin n_fail++; $display("FAIL drain%0d_card: got rank=%0d suit=%0d pts=%0d ace=%b left=%0d, want %0d %0d %0d %b %0d",
              nd, o_rank[k], o_suit[k], o_pts[k], o_ace[k], o_left[k], er, e.idx % 4, ep, er == 4'd1, e.left); end
          lat = cyc_n - e.acc;
          n_tests++;
          if (cyc_n !== e.due || lat < 2 || lat > 53)
            begin n_fail++; $display("FAIL drain%0d_latency: got %0d, want %0d (2..53)", nd, lat, e.due - e.acc); end
        end
        seen[(int'(o_rank[k]) - 1) * 4 + int'(o_suit[k])]++;
        if (run == 1 && got < 52) seq_a[got] = int'(o_rank[k]) * 4 + int'(o_suit[k]);
        if (run == 2 && got < 52) seq_b[got] = int'(o_rank[k]) * 4 + int'(o_suit[k]);
        got++;
      end else if (m_vexp[k]) begin
        n_tests++;
        n_fail++;
        $display("FAIL drain%0d_missing_card: got no card_valid, want one at cyc %0d", nd, cyc_n);
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        got++;
      end
    end
    n_tests++;
    if (pulses !== 52 * nd) begin n_fail++; $display("FAIL drain%0d_count: got %0d pulses, want %0d", nd, pulses, 52 * nd); end
    bad = 0;
    foreach (seen[i]) if (seen[i] != nd) bad++;
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL drain%0d_unique: got %0d cards with wrong multiplicity, want 0", nd, bad); end
    n_tests++;
    if ({o_left[k], o_empty[k], o_ready[k]} !== {7'd0, 1'b1, 1'b0})
      begin n_fail++; $display("FAIL drain%0d_empty: got left=%0d empty=%b ready=%b, want 0 1 0", nd, o_left[k], o_empty[k], o_ready[k]); end
    for (int i = 0; i < 10; i++) begin
      cyc();
      n_tests++;
      if (o_valid[k] !== 1'b0 || o_ready[k] !== 1'b0)
        begin n_fail++; $display("FAIL drain%0d_after_empty: got valid=%b ready=%b, want 0 0", nd, o_valid[k], o_ready[k]); end
    end
    draw_req[k] = 1'b0;
  endtask

  task automatic test_shuffle_probe();
    shuffle = 1'b1;
    cyc();
    shuffle = 1'b0;
    repeat (52) cyc();
    n_tests++;
    if ({d1_ready, d1_left} !== {1'b1, 6'd52}) begin n_fail++; $display("FAIL refill: got ready=%b left=%0d, want 1 52", d1_ready, d1_left); end
    draw_req[0] = 1'b1;
    cyc();
    draw_req[0] = 1'b0;
    n_tests++;
    if (d1_busy !== 1'b1) begin n_fail++; $display("FAIL probe_busy: got busy=%b, want 1", d1_busy); end
    shuffle = 1'b1;
    cyc();
    shuffle = 1'b0;
    for (int i = 0; i < 52; i++) begin
      n_tests++;
      if (d1_busy !== 1'b1 || d1_valid !== 1'b0)
        begin n_fail++; $display("FAIL probe_shuffle_fill%0d: got busy=%b valid=%b, want 1 0", i, d1_busy, d1_valid); end
      cyc();
    end
    n_tests++;
    if ({d1_busy, d1_valid, d1_left} !== {1'b0, 1'b0, 6'd52})
      begin n_fail++; $display("FAIL probe_shuffle_done: got busy=%b valid=%b left=%0d, want 0 0 52", d1_busy, d1_valid, d1_left); end
  endtask

  task automatic test_shuffle_draw();
    draw_req[0] = 1'b1;
    shuffle = 1'b1;
    cyc();
    draw_req[0] = 1'b0;
    shuffle = 1'b0;
    for (int i = 0; i < 52; i++) begin
      n_tests++;
      if (d1_busy !== 1'b1 || d1_valid !== 1'b0)
        begin n_fail++; $display("FAIL shuffle_draw_fill%0d: got busy=%b valid=%b, want 1 0", i, d1_busy, d1_valid); end
      cyc();
    end
    n_tests++;
    if ({d1_ready, d1_valid, d1_left} !== {1'b1, 1'b0, 6'd52})
      begin n_fail++; $display("FAIL shuffle_draw_done: got ready=%b valid=%b left=%0d, want 1 0 52", d1_ready, d1_valid, d1_left); end
  endtask

  task automatic test_repeat();
    int diff;
    for (int r = 1; r <= 2; r++) begin
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      repeat (52) cyc();
      test_drain(0, r);
    end
    diff = 0;
    for (int i = 0; i < 52; i++) if (seq_a[i] != seq_b[i]) diff++;
    n_tests++;
    if (diff !== 0) begin n_fail++; $display("FAIL repeat_sequence: got %0d differing cards, want 0", diff); end
  endtask

  initial begin
    draw_req[0] = 1'b0;
    draw_req[1] = 1'b0;
    @(negedge clk);
    test_reset();
    test_drain(0, 0);
    test_drain(1, 0);
    test_shuffle_probe();
    test_shuffle_draw();
    test_repeat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
